// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush sequencer: FSM encodings,
// the default watchdog limit and the packed pipeline-register control bundle.
package pipe_ctrl_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_FAULT    = 2'd2;

    localparam int MEM_TIMEOUT_DEF = 64;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic memwb_en;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_HOLD = '0;
    localparam pipe_ctrl_t CTRL_FLOW = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
                                         idex_en: 1'b1, idex_flush: 1'b0,
                                         exmem_en: 1'b1, memwb_en: 1'b1};

    // Normal-flow decisions; a taken branch wins over a load-use bubble.
    // The bubble needs idex_en high so the flush actually loads into ID/EX.
    function automatic pipe_ctrl_t run_ctrl(input logic branch_taken, input logic load_use);
        pipe_ctrl_t c;
        c = CTRL_FLOW;
        if (branch_taken) begin
            c.ifid_flush = 1'b1;
            c.idex_flush = 1'b1;
        end else if (load_use) begin
            c.pc_en      = 1'b0;
            c.ifid_en    = 1'b0;
            c.idex_flush = 1'b1;
        end
        return c;
    endfunction

endpackage

// File: rtl/pipe_wait_timer.sv
// Saturating watchdog counter for data-memory waits; timeout flags the last
// permitted wait cycle (count == MEM_TIMEOUT-1).
module pipe_wait_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic timeout
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TW-1:0] LAST = TW'(MEM_TIMEOUT - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = (cnt_q == LAST);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: load-use bubbles, branch
// flushes, data-memory wait stalls and a sticky timeout fault.
// Optional stall_cnt performance output when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int regindex    = 5,
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [regindex-1:0] id_rs1,
    input  logic [regindex-1:0] id_rs2,
    input  logic [regindex-1:0] idex_rd,
    input  logic                idex_memread,
    input  logic                ex_branch_taken,
    input  logic                exmem_mem_req,
    input  logic                dmem_ready,
    output logic                pc_en,
    output logic                ifid_en,
    output logic                ifid_flush,
    output logic                idex_en,
    output logic                idex_flush,
    output logic                exmem_en,
    output logic                memwb_en,
    output logic                fault,
    output logic [1:0]          state
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]    stall_cnt
`endif
);

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       load_use;
    logic       tmr_clr;
    logic       tmr_inc;
    logic       tmr_timeout;
    pipe_ctrl_t ctrl;
    pipe_ctrl_t ctrl_out;

    assign load_use = idex_memread && (idex_rd != '0) &&
                      ((idex_rd == id_rs1) || (idex_rd == id_rs2));

    always_comb begin
        state_d = state_q;
        ctrl    = CTRL_HOLD;
        tmr_clr = 1'b0;
        tmr_inc = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (exmem_mem_req && !dmem_ready) begin
                    state_d = ST_MEM_WAIT;
                    tmr_inc = 1'b1;
                end else begin
                    ctrl = run_ctrl(ex_branch_taken, load_use);
                end
            end
            ST_MEM_WAIT: begin
                // Flushes stay suppressed while frozen; a branch held in EX is
                // re-evaluated on the release cycle.
                if (!dmem_ready) begin
                    tmr_inc = 1'b1;
                    if (tmr_timeout) begin
                        state_d = ST_FAULT;
                    end
                end else begin
                    ctrl    = run_ctrl(ex_branch_taken, load_use);
                    state_d = ST_RUN;
                    tmr_clr = 1'b1;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_RUN;
                tmr_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .inc    (tmr_inc),
        .timeout(tmr_timeout)
    );

    // The reset state is RUN, whose decode would enable everything; mask it.
    assign ctrl_out   = rst ? ctrl : CTRL_HOLD;
    assign pc_en      = ctrl_out.pc_en;
    assign ifid_en    = ctrl_out.ifid_en;
    assign ifid_flush = ctrl_out.ifid_flush;
    assign idex_en    = ctrl_out.idex_en;
    assign idex_flush = ctrl_out.idex_flush;
    assign exmem_en   = ctrl_out.exmem_en;
    assign memwb_en   = ctrl_out.memwb_en;
    assign fault      = (state_q == ST_FAULT);
    assign state      = state_q;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!ctrl_out.pc_en && (state_q != ST_FAULT) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
